// File: rtl/dout_display_if.sv
// ---------------------------------------------------------------------------
// dout_display_if
// Carries the CPU output word into the display stage.
//   Value       8  value to show (CPU Dout)
//   Valid       1  value is meaningful (CPU Dval)
//   SignedMode  1  1 = interpret Value as two's complement
// master drives the bus (CPU side), slave consumes it (display side).
// ---------------------------------------------------------------------------
interface dout_display_if;
    logic [7:0] Value;
    logic       Valid;
    logic       SignedMode;

    modport master (output Value, Valid, SignedMode);
    modport slave  (input  Value, Valid, SignedMode);
endinterface

// File: rtl/dout_display.sv
// ---------------------------------------------------------------------------
// dout_display
// Shows the CPU output word on a 4-digit multiplexed, active-low 7-segment
// display as sign / hundreds / tens / ones. The binary value is converted to
// BCD with a sequential double-dabble engine (one bit per cycle). A new
// conversion starts whenever the bus differs from the copy captured for the
// previous conversion.
//
// Ports
//   Clock   in   system clock, all state on posedge
//   Reset   in   synchronous, active-high
//   cpu     slave modport of dout_display_if (Value, Valid, SignedMode)
//   Seg     out  segments {g,f,e,d,c,b,a}, active-low, registered
//   DP      out  decimal point, active-low, always off
//   Anode   out  digit enables, active-low, bit 3 = sign digit, registered
//   Busy    out  high while a conversion is in progress
// ---------------------------------------------------------------------------
module dout_display #(
    parameter int REFRESH_DIV = 50000,  // clock cycles per digit slot, >= 2
    parameter bit LZ_BLANK    = 1'b1    // blank leading zeros of hundreds/tens
) (
    input  logic                 Clock,
    input  logic                 Reset,
    dout_display_if.slave        cpu,
    output logic [6:0]           Seg,
    output logic                 DP,
    output logic [3:0]           Anode,
    output logic                 Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    // Display digit codes: 0..9 are decimal digits, the rest are symbols.
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // -----------------------------------------------------------------------
    // Conversion control
    // -----------------------------------------------------------------------
    state_t      state, state_next;
    logic        force_conv;        // forces one conversion after reset
    logic [7:0]  last_value;
    logic        last_valid;
    logic        last_signed;
    logic        cap_neg;
    logic [19:0] dd_reg;            // {hundreds, tens, ones, magnitude}
    logic [2:0]  bit_cnt;

    logic        inputs_changed;
    logic        capture;
    logic [7:0]  mag_in;
    logic        neg_in;

    assign inputs_changed = {cpu.Value, cpu.Valid, cpu.SignedMode}
                         != {last_value, last_valid, last_signed};
    assign capture        = (state == S_IDLE) && (force_conv || inputs_changed);

    // Negating 8'h80 wraps back to 8'h80, which read as unsigned is 128.
    assign neg_in = cpu.SignedMode & cpu.Value[7];
    assign mag_in = neg_in ? 8'(~cpu.Value + 8'd1) : cpu.Value;

    // NOTE: every signal written in always_comb gets a default at the top so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (force_conv || inputs_changed) state_next = S_SHIFT;
            S_SHIFT:  if (bit_cnt == 3'd7)              state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the pre-edge values of the others, as real flops do.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            force_conv <= 1'b1;
        end else begin
            state <= state_next;
            if (capture) force_conv <= 1'b0;
        end
    end

    assign Busy = (state != S_IDLE);

    // One double-dabble iteration: correct each BCD nibble >= 5, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    // NOTE: the datapath registers carry no reset; the force flag guarantees
    // a fresh capture before anything here is used after reset.
    always_ff @(posedge Clock) begin
        if (!Reset && capture) begin
            last_value  <= cpu.Value;
            last_valid  <= cpu.Valid;
            last_signed <= cpu.SignedMode;
            cap_neg     <= neg_in;
            dd_reg      <= {12'd0, mag_in};
            bit_cnt     <= 3'd0;
        end else if (state == S_SHIFT) begin
            dd_reg  <= dd_step(dd_reg);
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Display digit registers, loaded only at COMMIT so a partial result or
    // an aborted conversion never reaches the pins.
    // -----------------------------------------------------------------------
    logic [3:0] digits [4];
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;

    assign bcd_hund = dd_reg[19:16];
    assign bcd_tens = dd_reg[15:12];
    assign bcd_ones = dd_reg[11:8];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) digits[i] <= DIG_BLANK;
        end else if (state == S_COMMIT) begin
            if (!last_valid) begin
                for (int i = 0; i < 4; i++) digits[i] <= DIG_DASH;
            end else begin
                digits[3] <= cap_neg ? DIG_DASH : DIG_BLANK;
                digits[2] <= (LZ_BLANK && bcd_hund == 4'd0) ? DIG_BLANK : bcd_hund;
                digits[1] <= (LZ_BLANK && bcd_hund == 4'd0 && bcd_tens == 4'd0)
                             ? DIG_BLANK : bcd_tens;
                digits[0] <= bcd_ones;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scan: free-running slot timer, independent of the conversion FSM.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            DIG_DASH: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    logic [3:0] sel_digit;
    assign sel_digit = digits[digit_idx];

    // Registered outputs track the digit registers directly, so a COMMIT is
    // visible on the next cycle rather than at the end of the current slot.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Seg   <= 7'h7F;
            Anode <= 4'hF;
        end else begin
            Seg   <= seg_code(sel_digit);
            Anode <= (sel_digit == DIG_BLANK) ? 4'hF : ~(4'b0001 << digit_idx);
        end
    end

    assign DP = 1'b1;

endmodule
